// File: rtl/mem_access_pkg.sv
// Shared types and constants for the burst memory access unit.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } mau_state_t;

    localparam int MAX_BURST_DEFAULT = 16;
    localparam int WORD_BYTES        = 4;

endpackage

// File: rtl/mau_addr_gen.sv
// Word address and remaining-count tracker for one burst.
module mau_addr_gen
    import mem_access_pkg::*;
#(
    parameter int N         = 32,
    parameter int MAX_BURST = MAX_BURST_DEFAULT,
    parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [N-1:0]     load_addr,
    input  logic [LEN_W-1:0] load_len,
    output logic [N-1:0]     address,
    output logic             last
);

    logic [N-1:0]     addr_r;
    logic [LEN_W-1:0] count_r;
    logic [LEN_W-1:0] len_s;

    // Zero-length requests still move one word; oversize requests clamp.
    always_comb begin
        if (load_len == {LEN_W{1'b0}}) begin
            len_s = LEN_W'(1);
        end else if (32'(load_len) > MAX_BURST) begin
            len_s = LEN_W'(MAX_BURST);
        end else begin
            len_s = load_len;
        end
    end

    // Address/count registers; the address wraps naturally modulo 2^N.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r  <= {N{1'b0}};
            count_r <= {LEN_W{1'b0}};
        end else if (load) begin
            addr_r  <= {load_addr[N-1:2], 2'b00};
            count_r <= len_s;
        end else if (step) begin
            addr_r  <= addr_r + N'(WORD_BYTES);
            count_r <= count_r - LEN_W'(1);
        end else begin
            addr_r  <= addr_r;
            count_r <= count_r;
        end
    end

    assign address = addr_r;
    assign last    = (count_r == LEN_W'(1));

endmodule

// File: rtl/mem_access_unit.sv
// Burst load/store initiator driving the data-memory port one word per cycle
// with valid/ready handshakes on both the store and load streams.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int N         = 32,
    parameter int MAX_BURST = MAX_BURST_DEFAULT,
    parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [N-1:0]     req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic [N-1:0]     wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [N-1:0]     rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             done,
    output logic             mem_write_enable,
    output logic [N-1:0]     mem_address,
    output logic [N-1:0]     mem_write_data,
    input  logic [N-1:0]     mem_read_data
);

    mau_state_t   state_r;
    mau_state_t   state_s;
    logic         load_s;
    logic         step_s;
    logic         last_s;
    logic         capture_s;
    logic [N-1:0] addr_s;
    logic [N-1:0] rd_data_r;
    logic         rd_valid_r;

    mau_addr_gen #(
        .N         (N),
        .MAX_BURST (MAX_BURST),
        .LEN_W     (LEN_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .step      (step_s),
        .load_addr (req_addr),
        .load_len  (req_len),
        .address   (addr_s),
        .last      (last_s)
    );

    // The output word register is free when empty or being handed off.
    assign capture_s = !rd_valid_r || rd_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_s          = state_r;
        req_ready        = 1'b0;
        wr_ready         = 1'b0;
        mem_write_enable = 1'b0;
        load_s           = 1'b0;
        step_s           = 1'b0;
        done             = 1'b0;
        case (state_r)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    load_s  = 1'b1;
                    state_s = req_write ? WRITE : READ;
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                wr_ready         = 1'b1;
                mem_write_enable = wr_valid;
                if (wr_valid) begin
                    step_s  = 1'b1;
                    state_s = last_s ? DONE : WRITE;
                end else begin
                    state_s = WRITE;
                end
            end
            READ: begin
                if (capture_s) begin
                    step_s  = 1'b1;
                    state_s = last_s ? DONE : READ;
                end else begin
                    state_s = READ;
                end
            end
            DONE: begin
                // Loads finish only once the final word has left the register.
                if (capture_s) begin
                    done    = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Load-side output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r  <= {N{1'b0}};
            rd_valid_r <= 1'b0;
        end else if ((state_r == READ) && capture_s) begin
            rd_data_r  <= mem_read_data;
            rd_valid_r <= 1'b1;
        end else if (rd_ready) begin
            rd_data_r  <= rd_data_r;
            rd_valid_r <= 1'b0;
        end else begin
            rd_data_r  <= rd_data_r;
            rd_valid_r <= rd_valid_r;
        end
    end

    assign rd_data        = rd_data_r;
    assign rd_valid       = rd_valid_r;
    assign mem_address    = addr_s;
    assign mem_write_data = wr_data;

endmodule
